// File: rtl/vm1_tve_pkg.sv
// vm1_tve_pkg: state encoding, register map and default constants for the timer bus controller
package vm1_tve_pkg;
  typedef enum logic [2:0] {IDLE, RD, MRG, WR, ACK, VEC, PASS} tve_state_t;
  localparam logic [15:0] LIM_OFS = 16'd0, CNT_OFS = 16'd2, CSR_OFS = 16'd4;
  localparam logic [15:0] DEF_BASE = 16'o177706, DEF_VECTOR = 16'o000270;
endpackage

// File: rtl/vm1_tve_bus_if.sv
// vm1_tve_bus_if: CPU-side bus cycle and interrupt-acknowledge signals
interface vm1_tve_bus_if;
  logic stb, we, ack, iak_i, iak_o, virq;
  logic [1:0] sel;
  logic [15:0] adr, dat_i, dat_o;
  modport slave(input stb, we, sel, adr, dat_i, iak_i, output dat_o, ack, iak_o, virq);
  modport master(output stb, we, sel, adr, dat_i, iak_i, input dat_o, ack, iak_o, virq);
endinterface

// File: rtl/vm1_tve_ena.sv
// vm1_tve_ena: free-running prescaler producing a one-clock timer enable every ENA_DIV clocks
module vm1_tve_ena #(parameter int ENA_DIV = 1) (
  input  logic tvb_clk,
  input  logic tvb_rst_n,
  output logic tve_ena
);
  localparam logic [7:0] LAST = 8'(ENA_DIV - 1);
  logic [7:0] cnt;
  always_ff @(posedge tvb_clk or negedge tvb_rst_n)
    if (!tvb_rst_n) begin
      cnt <= '0;
      tve_ena <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 8'd1;
      tve_ena <= cnt == LAST;
    end
endmodule

// File: rtl/vm1_tve_bus.sv
// vm1_tve_bus: sequences CPU reads, byte-merged writes and vector acknowledge for vm1_timer
module vm1_tve_bus import vm1_tve_pkg::*; #(
  parameter logic [15:0] BASE = DEF_BASE,
  parameter logic [15:0] VECTOR = DEF_VECTOR,
  parameter int ENA_DIV = 1
) (
  input  logic        tvb_clk,
  input  logic        tvb_rst_n,
  vm1_tve_bus_if.slave tvb,
  output logic        tve_ena,
  output logic [15:0] tve_din,
  input  logic [15:0] tve_dout,
  output logic        tve_csr_oe,
  output logic        tve_cnt_oe,
  output logic        tve_lim_oe,
  output logic        tve_csr_wr,
  output logic        tve_lim_wr,
  input  logic        tve_irq,
  output logic        tve_ack
);
  localparam logic [15:0] A_LIM = BASE + LIM_OFS, A_CNT = BASE + CNT_OFS, A_CSR = BASE + CSR_OFS;
  tve_state_t st;
  logic hit_lim, hit_cnt, hit_csr, hit;
  logic [15:0] mrg;
  // forcing bit 0 high on both sides makes the compare word-granular
  assign hit_lim = (tvb.adr | 16'd1) == (A_LIM | 16'd1);
  assign hit_cnt = (tvb.adr | 16'd1) == (A_CNT | 16'd1);
  assign hit_csr = (tvb.adr | 16'd1) == (A_CSR | 16'd1);
  assign hit = hit_lim | hit_cnt | hit_csr;
  assign mrg = {tvb.sel[1] ? tvb.dat_i[15:8] : tve_dout[15:8], tvb.sel[0] ? tvb.dat_i[7:0] : tve_dout[7:0]};
  assign tvb.virq = tve_irq;
  vm1_tve_ena #(.ENA_DIV(ENA_DIV)) u_ena (.tvb_clk, .tvb_rst_n, .tve_ena);
  always_ff @(posedge tvb_clk or negedge tvb_rst_n)
    if (!tvb_rst_n) begin
      st <= IDLE;
      tvb.dat_o <= '0;
      tvb.ack <= 1'b0;
      tvb.iak_o <= 1'b0;
      tve_din <= '0;
      {tve_csr_oe, tve_cnt_oe, tve_lim_oe, tve_csr_wr, tve_lim_wr, tve_ack} <= '0;
    end else begin
      {tve_csr_oe, tve_cnt_oe, tve_lim_oe, tve_csr_wr, tve_lim_wr, tve_ack} <= '0;
      case (st)
        IDLE:
          if (tvb.stb && hit && !tvb.we) begin
            st <= RD;
            {tve_lim_oe, tve_cnt_oe, tve_csr_oe} <= {hit_lim, hit_cnt, hit_csr};
          end else if (tvb.stb && hit) begin
            if (hit_lim && &tvb.sel) begin
              st <= WR;
              tve_lim_wr <= 1'b1;
              tve_din <= tvb.dat_i;
            end else if (hit_lim && ^tvb.sel) begin
              st <= MRG;
              tve_lim_oe <= 1'b1;
            end else if (hit_csr && tvb.sel[0]) begin
              st <= WR;
              tve_csr_wr <= 1'b1;
              tve_din <= tvb.dat_i;
            end else begin
              st <= ACK;
              tvb.ack <= 1'b1;
            end
          end else if (tvb.iak_i && tve_irq) begin
            st <= VEC;
            tvb.dat_o <= VECTOR;
            tvb.ack <= 1'b1;
            tve_ack <= 1'b1;
          end else if (tvb.iak_i) begin
            st <= PASS;
            tvb.iak_o <= 1'b1;
          end
        RD: begin
          st <= ACK;
          tvb.ack <= 1'b1;
          tvb.dat_o <= tve_dout;
        end
        MRG: begin
          st <= WR;
          tve_lim_wr <= 1'b1;
          tve_din <= mrg;
        end
        WR: begin
          st <= ACK;
          tvb.ack <= 1'b1;
          tve_din <= '0;
        end
        ACK, VEC:
          if (!(st == ACK ? tvb.stb : tvb.iak_i)) begin
            st <= IDLE;
            tvb.ack <= 1'b0;
            tvb.dat_o <= '0;
          end
        PASS:
          if (!tvb.iak_i) begin
            st <= IDLE;
            tvb.iak_o <= 1'b0;
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vm1_tve_bus.sv
// tb_vm1_tve_bus: randomized self-checking bench with a timer register model and strobe monitor
module tb_vm1_tve_bus;
  localparam logic [15:0] A_LIM = 16'o177706, A_CNT = 16'o177710, A_CSR = 16'o177712, VEC_V = 16'o000270;
  logic clk = 1'b0, rst_n = 1'b0, irq = 1'b0;
  logic ena, ena1, csr_oe, cnt_oe, lim_oe, csr_wr, lim_wr, tack;
  logic [15:0] din, dout, t_lim, t_cnt, ref_lim, last_din;
  logic [7:0] t_csr, ref_csr;
  int checks = 0, errors = 0;
  int c[9], s[9];
  always #5 clk = ~clk;
  vm1_tve_bus_if bus();
  vm1_tve_bus #(.ENA_DIV(4)) dut (.tvb_clk(clk), .tvb_rst_n(rst_n), .tvb(bus), .tve_ena(ena), .tve_din(din),
    .tve_dout(dout), .tve_csr_oe(csr_oe), .tve_cnt_oe(cnt_oe), .tve_lim_oe(lim_oe), .tve_csr_wr(csr_wr),
    .tve_lim_wr(lim_wr), .tve_irq(irq), .tve_ack(tack));
  vm1_tve_ena #(.ENA_DIV(1)) u_e1 (.tvb_clk(clk), .tvb_rst_n(rst_n), .tve_ena(ena1));
  // timer register file model
  always @(posedge clk) begin
    if (lim_wr) t_lim <= din;
    if (csr_wr) t_csr <= din[7:0];
  end
  assign dout = csr_oe ? {8'hFF, t_csr} : cnt_oe ? t_cnt : lim_oe ? t_lim : 16'hDEAD;
  // per-cycle tallies: 0 csr_oe 1 cnt_oe 2 lim_oe 3 csr_wr 4 lim_wr 5 ack 6 tve_ack 7 iak_o 8 strobe rule breaks
  always @(negedge clk) begin
    c[0] += int'(csr_oe); c[1] += int'(cnt_oe); c[2] += int'(lim_oe);
    c[3] += int'(csr_wr); c[4] += int'(lim_wr); c[5] += int'(bus.ack);
    c[6] += int'(tack); c[7] += int'(bus.iak_o);
    c[8] += int'((int'(csr_oe) + int'(cnt_oe) + int'(lim_oe)) > 1 || (csr_wr && lim_wr) ||
                 ((csr_oe || cnt_oe || lim_oe) && (csr_wr || lim_wr)) || (din != 16'd0 && !(csr_wr || lim_wr)));
    if (csr_wr || lim_wr) last_din = din;
  end
  function automatic int d(int i);
    return c[i] - s[i];
  endfunction
  task automatic bus_cycle(input logic we, input logic [1:0] sel, input logic [15:0] adr, dat,
                           output int lat, output logic [15:0] rd, output logic ack_after, output logic [15:0] dat_after);
    @(posedge clk); #1;
    s = c;
    bus.stb = 1'b1; bus.we = we; bus.sel = sel; bus.adr = adr; bus.dat_i = dat;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.ack && lat < 20);
    rd = bus.dat_o;
    bus.stb = 1'b0; bus.we = 1'($urandom); bus.dat_i = 16'($urandom);
    @(posedge clk); #1;
    ack_after = bus.ack; dat_after = bus.dat_o;
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if ({bus.ack, bus.iak_o, bus.dat_o, din, ena, ena1, csr_oe, cnt_oe, lim_oe, csr_wr, lim_wr, tack} !== '0) begin
      errors++; $display("FAIL reset_outputs got ack=%b dat_o=%h din=%h ena=%b want all 0", bus.ack, bus.dat_o, din, ena);
    end
    irq = 1'b1; #1;
    checks++;
    if (bus.virq !== 1'b1) begin errors++; $display("FAIL reset_virq_hi got %b want 1", bus.virq); end
    irq = 1'b0; #1;
    checks++;
    if (bus.virq !== 1'b0) begin errors++; $display("FAIL reset_virq_lo got %b want 0", bus.virq); end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_full_write;
    int lat; logic aa; logic [15:0] rd, da, v; logic [1:0] sel;
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      sel = (i % 2 == 0 || $urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
      bus_cycle(1'b1, sel, (i % 2 == 0) ? A_LIM : A_CSR, v, lat, rd, aa, da);
      if (i % 2 == 0) ref_lim = v; else ref_csr = v[7:0];
      checks++;
      if (lat != 2 || aa !== 1'b0) begin errors++; $display("FAIL fw_latency got %0d ack_after=%b want 2/0", lat, aa); end
      checks++;
      if (d(i % 2 == 0 ? 4 : 3) != 1 || d(3) + d(4) != 1 || d(0) + d(1) + d(2) != 0 || d(8) != 0) begin
        errors++; $display("FAIL fw_strobes got lim_wr=%0d csr_wr=%0d oe=%0d bad=%0d want one wr", d(4), d(3), d(0)+d(1)+d(2), d(8));
      end
      checks++;
      if (last_din !== v || t_lim !== ref_lim || t_csr !== ref_csr) begin
        errors++; $display("FAIL fw_data got din=%h lim=%h csr=%h want %h %h %h", last_din, t_lim, t_csr, v, ref_lim, ref_csr);
      end
    end
  endtask
  task automatic test_read;
    int lat, r; logic aa; logic [15:0] rd, da, exp;
    bus_cycle(1'b1, 2'b01, A_CSR, 16'h0010, lat, rd, aa, da);
    ref_csr = 8'h10;
    for (int i = 0; i < 9; i++) begin
      r = (i == 0) ? 2 : $urandom_range(0, 2);
      t_cnt = 16'($urandom);
      exp = (r == 0) ? ref_lim : (r == 1) ? t_cnt : {8'hFF, ref_csr};
      bus_cycle(1'b0, 2'($urandom), r == 0 ? A_LIM : r == 1 ? A_CNT : A_CSR, 16'($urandom), lat, rd, aa, da);
      checks++;
      if (lat != 2 || rd !== exp) begin errors++; $display("FAIL rd_data r=%0d got %h lat %0d want %h lat 2", r, rd, lat, exp); end
      checks++;
      if (d(2 - r) != 1 || d(0) + d(1) + d(2) != 1 || d(3) + d(4) != 0 || d(5) != 1) begin
        errors++; $display("FAIL rd_strobes r=%0d got oe=%0d/%0d wr=%0d ack=%0d want 1/1/0/1", r, d(2-r), d(0)+d(1)+d(2), d(3)+d(4), d(5));
      end
      checks++;
      if (aa !== 1'b0 || da !== 16'd0) begin errors++; $display("FAIL rd_clear got ack=%b dat_o=%h want 0 0", aa, da); end
    end
    checks++;
    if (exp !== 16'o177420 && r == 2) begin errors++; $display("FAIL rd_csr_const got %h want %h", exp, 16'o177420); end
  endtask
  task automatic test_lim_byte;
    int lat; logic aa; logic [15:0] rd, da, v, exp; logic [1:0] sel;
    bus_cycle(1'b1, 2'b11, A_LIM, 16'h1234, lat, rd, aa, da);
    ref_lim = 16'h1234;
    for (int i = 0; i < 7; i++) begin
      v = (i == 0) ? 16'hAB00 : 16'($urandom);
      sel = (i == 0) ? 2'b10 : 2'($urandom_range(1, 2));
      exp = (sel == 2'b10) ? {v[15:8], ref_lim[7:0]} : {ref_lim[15:8], v[7:0]};
      if (i == 0) exp = 16'hAB34;
      bus_cycle(1'b1, sel, A_LIM, v, lat, rd, aa, da);
      ref_lim = exp;
      checks++;
      if (lat != 3 || aa !== 1'b0) begin errors++; $display("FAIL byte_latency got %0d want 3", lat); end
      checks++;
      if (d(2) != 1 || d(4) != 1 || d(0) + d(1) + d(3) != 0 || d(8) != 0) begin
        errors++; $display("FAIL byte_strobes got lim_oe=%0d lim_wr=%0d other=%0d bad=%0d want 1 1 0 0", d(2), d(4), d(0)+d(1)+d(3), d(8));
      end
      checks++;
      if (last_din !== exp || t_lim !== exp) begin errors++; $display("FAIL byte_merge sel=%b got din=%h lim=%h want %h", sel, last_din, t_lim, exp); end
    end
  endtask
  task automatic test_ignored;
    int lat; logic aa; logic [15:0] rd, da, a; logic [1:0] sel; logic [15:0] pl; logic [7:0] pc;
    for (int i = 0; i < 5; i++) begin
      a = (i < 2) ? A_CNT : (i == 3) ? A_LIM : A_CSR;
      sel = (i == 0) ? 2'b11 : (i == 1) ? 2'($urandom) : (i == 2) ? 2'b10 : 2'b00;
      pl = ref_lim; pc = ref_csr;
      bus_cycle(1'b1, sel, a, 16'($urandom), lat, rd, aa, da);
      checks++;
      if (lat != 1 || d(5) != 1 || aa !== 1'b0) begin errors++; $display("FAIL ign_latency i=%0d got %0d ack=%0d want 1", i, lat, d(5)); end
      checks++;
      if (d(0) + d(1) + d(2) + d(3) + d(4) != 0 || t_lim !== pl || t_csr !== pc) begin
        errors++; $display("FAIL ign_strobes i=%0d got strobes=%0d lim=%h want 0 %h", i, d(0)+d(1)+d(2)+d(3)+d(4), t_lim, pl);
      end
    end
    @(posedge clk); #1;
    s = c;
    bus.stb = 1'b1; bus.we = 1'($urandom); bus.sel = 2'b11; bus.adr = A_CSR + 16'd2;
    repeat (4) begin @(posedge clk); #1; end
    bus.adr = A_LIM - 16'd2;
    repeat (4) begin @(posedge clk); #1; end
    bus.stb = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (d(5) + d(0) + d(1) + d(2) + d(3) + d(4) != 0) begin errors++; $display("FAIL miss got ack+strobes=%0d want 0", d(5)+d(0)+d(1)+d(2)+d(3)+d(4)); end
  endtask
  task automatic test_vec;
    logic held = 1'b1;
    @(posedge clk); #1;
    s = c;
    irq = 1'b1; bus.iak_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 1'b1 || tack !== 1'b1 || bus.dat_o !== VEC_V || bus.virq !== 1'b1) begin
      errors++; $display("FAIL vec_entry got ack=%b tve_ack=%b dat_o=%h want 1 1 %h", bus.ack, tack, bus.dat_o, VEC_V);
    end
    for (int i = 0; i < int'($urandom_range(2, 5)); i++) begin
      irq = 1'(i % 2);
      @(posedge clk); #1;
      held &= bus.ack;
    end
    bus.iak_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!held || bus.ack !== 1'b0) begin errors++; $display("FAIL vec_hold got held=%b ack_after=%b want 1 0", held, bus.ack); end
    checks++;
    if (d(6) != 1 || d(7) != 0) begin errors++; $display("FAIL vec_pulse got tve_ack=%0d iak_o=%0d want 1 0", d(6), d(7)); end
    irq = 1'b0;
  endtask
  task automatic test_pass;
    int n = $urandom_range(2, 6);
    @(posedge clk); #1;
    s = c;
    bus.iak_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == n / 2) irq = 1'b1;
    end
    bus.iak_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (d(7) != n || d(5) != 0 || d(6) != 0 || bus.iak_o !== 1'b0) begin
      errors++; $display("FAIL pass got iak_o=%0d ack=%0d tve_ack=%0d want %0d 0 0", d(7), d(5), d(6), n);
    end
    irq = 1'b0;
  endtask
  task automatic test_prio;
    @(posedge clk); #1;
    s = c;
    irq = 1'b1; bus.iak_i = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = A_CSR; bus.sel = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (csr_oe !== 1'b1 || bus.ack !== 1'b0 || tack !== 1'b0) begin errors++; $display("FAIL prio_rd got csr_oe=%b tve_ack=%b want 1 0", csr_oe, tack); end
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 1'b1 || bus.dat_o !== {8'hFF, ref_csr}) begin errors++; $display("FAIL prio_data got %h want %h", bus.dat_o, {8'hFF, ref_csr}); end
    bus.stb = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 1'b0) begin errors++; $display("FAIL prio_gap got ack=%b want 0", bus.ack); end
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 1'b1 || tack !== 1'b1 || bus.dat_o !== VEC_V || d(7) != 0) begin
      errors++; $display("FAIL prio_vec got ack=%b tve_ack=%b dat_o=%h want 1 1 %h", bus.ack, tack, bus.dat_o, VEC_V);
    end
    bus.iak_i = 1'b0; irq = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_ena;
    int f = -1, mism = 0, ones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (f < 0 && ena) f = i;
      if (f >= 0 && ena !== ((i - f) % 4 == 0)) mism++;
      ones += int'(ena1);
    end
    checks++;
    if (f < 0 || f > 3 || mism != 0) begin errors++; $display("FAIL ena_div4 got first=%0d mism=%0d want first<4 mism 0", f, mism); end
    checks++;
    if (ones != 40) begin errors++; $display("FAIL ena_div1 got %0d want 40", ones); end
  endtask
  task automatic test_async_reset;
    int lat; logic aa; logic [15:0] rd, da, pl = ref_lim;
    @(posedge clk); #1;
    s = c;
    bus.stb = 1'b1; bus.we = 1'b1; bus.sel = 2'b11; bus.adr = A_LIM; bus.dat_i = ~ref_lim;
    @(posedge clk); #1;
    checks++;
    if (lim_wr !== 1'b1) begin errors++; $display("FAIL arst_pre got lim_wr=%b want 1", lim_wr); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lim_wr !== 1'b0 || bus.ack !== 1'b0 || din !== 16'd0) begin errors++; $display("FAIL arst_drop got lim_wr=%b ack=%b din=%h want 0", lim_wr, bus.ack, din); end
    bus.stb = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (d(5) != 0 || d(4) != 0 || t_lim !== pl) begin errors++; $display("FAIL arst_abort got ack=%0d lim_wr=%0d lim=%h want 0 0 %h", d(5), d(4), t_lim, pl); end
    bus_cycle(1'b0, 2'b11, A_LIM, 16'd0, lat, rd, aa, da);
    checks++;
    if (lat != 2 || rd !== pl) begin errors++; $display("FAIL arst_idle got %h lat %0d want %h lat 2", rd, lat, pl); end
  endtask
  initial begin
    bus.stb = 1'b0; bus.we = 1'b0; bus.sel = 2'b00; bus.adr = 16'd0; bus.dat_i = 16'd0; bus.iak_i = 1'b0;
    t_cnt = 16'd0;
    test_reset;
    test_full_write;
    test_read;
    test_lim_byte;
    test_ignored;
    test_vec;
    test_pass;
    test_prio;
    test_ena;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
